// File: rtl/pl_ddr_axi_wr.sv
// Buffers the 32-bit frame stream in a FWFT FIFO and writes each frame to PL DDR as AXI4 INCR bursts.
// Define PL_DDR_WR_TEST_PATTERN_EN to replace the FIFO write data with an incrementing counter.
module pl_ddr_axi_wr #(
    parameter logic [31:0] DDR_BASE   = 32'h0000_0000,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 512
) (
    input  logic        pl_clk,
    input  logic        rst_n,
    input  logic        pl_ddr_wr_start,
    input  logic [31:0] pl_ddr_wr_length,
    input  logic [31:0] pl_ddr_wr_addr,
    input  logic        pl_ddr_wr_en,
    input  logic [31:0] pl_ddr_wr_data,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        wr_busy,
    output logic        wr_done,
    output logic        fifo_ovf,
    output logic        cmd_ovf,
    output logic        resp_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE     = (AW + 1)'(1);
    localparam logic [8:0]  BURST_C = 9'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_count;
    logic        fifo_full, fifo_push, fifo_pop;
    logic [31:0] fifo_wdata;

    logic [29:0] words_rem, pend_words, cmd_words;
    logic [31:0] cur_addr, pend_addr, cmd_addr;
    logic        pend_vld;
    logic [8:0]  beats;
    logic [7:0]  beat_cnt;
    logic        last_burst, done_last, take_pend;
    logic        start_to_act, start_to_pend, start_drop, aw_load;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign fifo_push  = pl_ddr_wr_en && !fifo_full;
    assign fifo_pop   = m_axi_wvalid && m_axi_wready;

`ifdef PL_DDR_WR_TEST_PATTERN_EN
    logic [31:0] pat_cnt;
    logic        unused_in;
    assign unused_in = ^{pl_ddr_wr_data, pl_ddr_wr_length[1:0], pl_ddr_wr_addr[1:0]};

    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n)         pat_cnt <= '0;
        else if (fifo_push) pat_cnt <= pat_cnt + 32'd1;
    end
    assign fifo_wdata = pat_cnt;
`else
    logic unused_in;
    assign unused_in  = ^{pl_ddr_wr_length[1:0], pl_ddr_wr_addr[1:0]};
    assign fifo_wdata = pl_ddr_wr_data;
`endif

    always_ff @(posedge pl_clk) begin
        if (fifo_push) mem[wr_ptr[AW-1:0]] <= fifo_wdata;
    end

    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + ONE;
            if (fifo_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // The pending slot frees on the cycle it is promoted, so a start that same cycle refills it.
    assign cmd_words     = pl_ddr_wr_length[31:2];
    assign cmd_addr      = DDR_BASE + {pl_ddr_wr_addr[31:2], 2'b00};
    assign beats         = (words_rem >= 30'(BURST_LEN)) ? BURST_C : words_rem[8:0];
    assign last_burst    = (words_rem == 30'(beats));
    assign done_last     = (state == RESP) && m_axi_bvalid && last_burst;
    assign take_pend     = pend_vld && ((state == IDLE) || done_last);
    assign start_to_act  = pl_ddr_wr_start && (state == IDLE) && !pend_vld;
    assign start_to_pend = pl_ddr_wr_start && !start_to_act && (!pend_vld || take_pend);
    assign start_drop    = pl_ddr_wr_start && !start_to_act && !start_to_pend;

    always_comb begin
        state_nxt = state;
        aw_load   = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: if (take_pend || start_to_act) state_nxt = WAIT_DATA;
            WAIT_DATA: begin
                if (words_rem == '0) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (32'(fifo_count) >= 32'(beats)) begin
                    aw_load   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: if (m_axi_awready) state_nxt = DATA;
            DATA: if (m_axi_wready && m_axi_wlast) state_nxt = RESP;
            RESP: begin
                if (m_axi_bvalid) begin
                    if (last_burst) begin
                        wr_done   = 1'b1;
                        state_nxt = pend_vld ? WAIT_DATA : IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            words_rem    <= '0;
            cur_addr     <= '0;
            pend_vld     <= 1'b0;
            pend_words   <= '0;
            pend_addr    <= '0;
            m_axi_awaddr <= '0;
            m_axi_awlen  <= '0;
            beat_cnt     <= '0;
            fifo_ovf     <= 1'b0;
            cmd_ovf      <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_pend) begin
                words_rem <= pend_words;
                cur_addr  <= pend_addr;
            end else if (start_to_act) begin
                words_rem <= cmd_words;
                cur_addr  <= cmd_addr;
            end else if ((state == RESP) && m_axi_bvalid) begin
                words_rem <= words_rem - 30'(beats);
                cur_addr  <= cur_addr + {21'b0, beats, 2'b00};
            end
            if (start_to_pend) begin
                pend_vld   <= 1'b1;
                pend_words <= cmd_words;
                pend_addr  <= cmd_addr;
            end else if (take_pend) begin
                pend_vld <= 1'b0;
            end
            if (aw_load) begin
                m_axi_awaddr <= cur_addr;
                m_axi_awlen  <= 8'(beats - 9'd1);
            end
            if (state == ADDR)  beat_cnt <= '0;
            else if (fifo_pop)  beat_cnt <= beat_cnt + 8'd1;
            if (pl_ddr_wr_en && fifo_full) fifo_ovf <= 1'b1;
            if (start_drop)                cmd_ovf  <= 1'b1;
            if ((state == RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) resp_err <= 1'b1;
        end
    end

    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = (state == ADDR);
    assign m_axi_wvalid  = (state == DATA);
    assign m_axi_wlast   = (state == DATA) && (beat_cnt == m_axi_awlen);
    assign m_axi_bready  = (state == RESP);
    assign m_axi_wdata   = m_axi_wvalid ? mem[rd_ptr[AW-1:0]] : '0;
    assign wr_busy       = (state != IDLE) || pend_vld;
endmodule

// File: tb/tb_pl_ddr_axi_wr.sv
// Scoreboard bench for pl_ddr_axi_wr: a frame-level model predicts AW bursts, W beats and completions.
module tb_pl_ddr_axi_wr;
    logic        pl_clk = 1'b0;
    logic        rst_n;
    logic        pl_ddr_wr_start, pl_ddr_wr_en;
    logic [31:0] pl_ddr_wr_length, pl_ddr_wr_addr, pl_ddr_wr_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        wr_busy, wr_done, fifo_ovf, cmd_ovf, resp_err;

    always #5 pl_clk = ~pl_clk;

    pl_ddr_axi_wr #(.DDR_BASE(32'h0000_0000), .BURST_LEN(16), .FIFO_DEPTH(512)) dut (
        .pl_clk(pl_clk), .rst_n(rst_n),
        .pl_ddr_wr_start(pl_ddr_wr_start), .pl_ddr_wr_length(pl_ddr_wr_length),
        .pl_ddr_wr_addr(pl_ddr_wr_addr), .pl_ddr_wr_en(pl_ddr_wr_en), .pl_ddr_wr_data(pl_ddr_wr_data),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .wr_busy(wr_busy),
        .wr_done(wr_done), .fifo_ovf(fifo_ovf), .cmd_ovf(cmd_ovf), .resp_err(resp_err)
    );

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] data_q[$];
    logic        last_q[$];
    int          total = 0, bad = 0;
    int          done_seen = 0, exp_done = 0;
    logic [31:0] pat = 0;
    int          w_pct = 100;
    logic        aw_rdy_en = 1'b1;
    int          err_at = -1, b_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pl_clk);
        #1;
    endtask

    // Frame model: split into bursts of at most 16 beats from the word-aligned start address.
    task automatic model_frame(input logic [31:0] len, input logic [31:0] addr);
        logic [31:0] a;
        int          rem, b;
        a   = 32'h0000_0000 + (addr & 32'hFFFF_FFFC);
        rem = int'(len >> 2);
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
            aw_addr_q.push_back(a);
            aw_len_q.push_back(8'(b - 1));
            for (int k = 0; k < b; k++) last_q.push_back(k == b - 1);
            a   = a + 32'(b * 4);
            rem = rem - b;
        end
        exp_done++;
    endtask

    task automatic drive_word(input logic st, input logic [31:0] len, input logic [31:0] addr);
        logic [31:0] d;
        d = $urandom();
        pl_ddr_wr_start  = st;
        pl_ddr_wr_length = len;
        pl_ddr_wr_addr   = addr;
        pl_ddr_wr_en     = 1'b1;
        pl_ddr_wr_data   = d;
`ifdef PL_DDR_WR_TEST_PATTERN_EN
        data_q.push_back(pat);
`else
        data_q.push_back(d);
`endif
        pat = pat + 32'd1;
        step();
        pl_ddr_wr_start = 1'b0;
        pl_ddr_wr_en    = 1'b0;
    endtask

    task automatic frame(input logic [31:0] len, input logic [31:0] addr, input int pct);
        int n;
        model_frame(len, addr);
        n = int'(len >> 2);
        if (n == 0) begin
            pl_ddr_wr_start  = 1'b1;
            pl_ddr_wr_length = len;
            pl_ddr_wr_addr   = addr;
            step();
            pl_ddr_wr_start = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) while ($urandom_range(99) >= pct) step();
                drive_word(i == 0, len, addr);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((wr_busy || aw_addr_q.size() != 0 || last_q.size() != 0) && cyc < 60000) begin
            step();
            cyc++;
        end
        check({name, "_finished"}, 64'(cyc < 60000), 1);
        check({name, "_done_cnt"}, 64'(done_seen), 64'(exp_done));
    endtask

    task automatic flush_model();
        aw_addr_q.delete();
        aw_len_q.delete();
        data_q.delete();
        last_q.delete();
        pat = 0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_awvalid"}, m_axi_awvalid, 0);
        check({name, "_wvalid"}, m_axi_wvalid, 0);
        check({name, "_bready"}, m_axi_bready, 0);
        check({name, "_wlast"}, m_axi_wlast, 0);
        check({name, "_busy"}, wr_busy, 0);
        check({name, "_done"}, wr_done, 0);
        check({name, "_flags"}, {fifo_ovf, cmd_ovf, resp_err}, 0);
        check({name, "_awaddr"}, m_axi_awaddr, 0);
        check({name, "_wdata"}, m_axi_wdata, 0);
    endtask

    // Monitor: compares every AW/W handshake against the model queues.
    initial begin
        forever begin
            @(negedge pl_clk);
            if (rst_n) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    check("aw_expected", 64'(aw_addr_q.size() > 0), 1);
                    check("awsize_burst", {m_axi_awsize, m_axi_awburst}, {3'b010, 2'b01});
                    if (aw_addr_q.size() > 0) begin
                        check("awaddr", m_axi_awaddr, aw_addr_q.pop_front());
                        check("awlen", m_axi_awlen, aw_len_q.pop_front());
                    end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    check("w_expected", 64'(data_q.size() > 0 && last_q.size() > 0), 1);
                    if (data_q.size() > 0 && last_q.size() > 0) begin
                        check("wdata", m_axi_wdata, data_q.pop_front());
                        check("wlast", m_axi_wlast, last_q.pop_front());
                    end
                end
                if (wr_done) done_seen++;
            end
        end
    end

    // AXI slave: one B response per completed W burst, randomized wready.
    initial begin
        int   pend_b;
        logic hs_w, hs_b;
        pend_b        = 0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(negedge pl_clk);
            hs_w = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            hs_b = m_axi_bvalid && m_axi_bready;
            @(posedge pl_clk);
            #1;
            if (!rst_n) begin
                pend_b       = 0;
                m_axi_bvalid = 1'b0;
            end else begin
                if (hs_b) m_axi_bvalid = 1'b0;
                if (hs_w) pend_b++;
                if (!m_axi_bvalid && pend_b > 0) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (b_idx == err_at) ? 2'b10 : 2'b00;
                    b_idx++;
                    pend_b--;
                end
            end
            m_axi_awready = aw_rdy_en;
            m_axi_wready  = ($urandom_range(99) < w_pct);
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n            = 1'b0;
        pl_ddr_wr_start  = 1'b0;
        pl_ddr_wr_en     = 1'b0;
        pl_ddr_wr_length = '0;
        pl_ddr_wr_addr   = '0;
        pl_ddr_wr_data   = '0;
        repeat (3) step();
        check_quiet("reset");
        check("reset_consts", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'b010, 2'b01, 4'hF});
        rst_n = 1'b1;
        step();

        frame(32000, 32'h0, 67);
        wait_idle("big");
        check("big_flags", {fifo_ovf, cmd_ovf, resp_err}, 0);

        frame(100, 32'h0, 50);
        wait_idle("len100");

        frame(0, 32'h40, 100);
        wait_idle("zero_len");

        w_pct = 50;
        frame(3200, 32'h0, 30);
        check("b2b_busy_at_start", wr_busy, 1);
        frame(640, 32000, 30);
        wait_idle("b2b");
        check("b2b_cmd_ovf", cmd_ovf, 0);

        w_pct = 70;
        for (int r = 0; r < 4; r++) begin
            frame($urandom_range(0, 1200), $urandom(), 40);
            frame($urandom_range(0, 1200), $urandom(), 40);
            wait_idle("random");
        end
        check("random_flags", {fifo_ovf, cmd_ovf, resp_err}, 0);

        w_pct  = 100;
        err_at = b_idx + 2;
        frame(320, 32'h4000, 60);
        wait_idle("resp_err_frame");
        check("resp_err_set", resp_err, 1);
        err_at = -1;

        aw_rdy_en = 1'b0;
        step();
        step();
        drive_word(1'b1, 64, 32'h0);
        drive_word(1'b1, 64, 32'h40);
        check("cmd_ovf_second", cmd_ovf, 0);
        drive_word(1'b1, 64, 32'h80);
        check("cmd_ovf_third", cmd_ovf, 1);
        for (int i = 3; i < 512; i++) drive_word(1'b0, 0, 0);
        check("fifo_ovf_512", fifo_ovf, 0);
        drive_word(1'b0, 0, 0);
        check("fifo_ovf_513", fifo_ovf, 1);
        aw_rdy_en = 1'b1;
        rst_n     = 1'b0;
        #1;
        flush_model();
        check_quiet("ovf_reset");
        step();
        rst_n = 1'b1;
        step();

        w_pct = 0;
        frame(64, 32'h100, 100);
        cyc = 0;
        while (!m_axi_wvalid && cyc < 200) begin
            step();
            cyc++;
        end
        check("reached_data", m_axi_wvalid, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_data_reset");
        flush_model();
        exp_done--;
        step();
        rst_n = 1'b1;
        w_pct = 100;
        step();
        frame(128, 32'h2000, 80);
        wait_idle("after_reset");
        check("after_reset_flags", {fifo_ovf, cmd_ovf, resp_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
